// File: rtl/counter_pkg.sv
// Shared counter definitions: run-state encoding and default counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_e;

endpackage : counter_pkg

// File: rtl/down_counter_with_reload.sv
// Loadable down-counter/timer with start/stop control, terminal-count pulse and optional auto-reload.
// Latency: every input takes effect on the next rising clk edge; all outputs are registered.
// Backpressure: none; load_i > stop_i > start_i > decrement, and no input is ever refused.
//
// Ports:
//   clk, reset_n       - rising-edge clock, asynchronous active-low reset
//   load_i/load_val_i  - write the preset into both the count and the reload register
//   start_i/stop_i     - begin/resume or pause counting (stop wins when both are high)
//   auto_reload_i      - at terminal count, restart from the stored preset instead of stopping
//   count_o            - current count
//   busy_o             - high while counting (RUN)
//   done_o             - one-cycle pulse following the terminal-count edge
module down_counter_with_reload
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q,   done_d;
    logic             busy_q,   busy_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load_i) begin
            count_d  = load_val_i;
            reload_d = load_val_i;
            // A zero preset leaves nothing to count, so park in IDLE without a pulse.
            if (load_val_i == '0) begin
                state_d = IDLE;
            end else if (start_i && !stop_i) begin
                state_d = RUN;
            end
        end else if (stop_i) begin
            if (state_q == RUN) begin
                state_d = PAUSED;
            end
        end else if (start_i && (state_q != RUN)) begin
            // Starting with an empty count is ignored; entry cycle does not decrement.
            if (count_q != '0) begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            // RUN always holds count_q >= 1, so the decrement cannot underflow.
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                done_d = 1'b1;
                // On reload the count jumps 1 -> preset, never showing 0,
                // so the period is exactly the preset value.
                if (auto_reload_i && (reload_q != '0)) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign count_o = count_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule : down_counter_with_reload

// File: tb/tb_down_counter_with_reload.sv
module tb_down_counter_with_reload;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         load_i = 1'b0;
    logic [W-1:0] load_val_i = '0;
    logic         start_i = 1'b0;
    logic         stop_i = 1'b0;
    logic         auto_reload_i = 1'b0;
    logic [W-1:0] count_o;
    logic         busy_o;
    logic         done_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    down_counter_with_reload #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_i        (load_i),
        .load_val_i    (load_val_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .auto_reload_i (auto_reload_i),
        .count_o       (count_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    typedef struct {
        logic         load;
        logic [W-1:0] val;
        logic         start;
        logic         stop;
        logic         auto_rl;
        int           e_count;
        int           e_busy;
        int           e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input int v, input logic st, input logic sp,
                                input logic ar, input int ec, input int eb, input int ed);
        vec_t r;
        r.load    = ld;
        r.val     = W'(v);
        r.start   = st;
        r.stop    = sp;
        r.auto_rl = ar;
        r.e_count = ec;
        r.e_busy  = eb;
        r.e_done  = ed;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input int ec, input int eb, input int ed);
        chk({tag, ".count"}, int'(count_o), ec);
        chk({tag, ".busy"},  int'(busy_o),  eb);
        chk({tag, ".done"},  int'(done_o),  ed);
    endtask

    // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic drive_step(input logic ld, input logic [W-1:0] v, input logic st,
                              input logic sp, input logic ar);
        load_i        = ld;
        load_val_i    = v;
        start_i       = st;
        stop_i        = sp;
        auto_reload_i = ar;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: only "counting or not" is observable (idle and paused
    // behave identically from outside), so it tracks a count, a preset, a
    // running flag and the pulse.
    int m_cnt, m_pre, m_done;
    bit m_run;

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_done = 0; m_run = 0;
    endtask

    task automatic model_edge(input bit ld, input int v, input bit st, input bit sp, input bit ar);
        m_done = 0;
        if (ld) begin
            m_cnt = v;
            m_pre = v;
            if (v == 0)          m_run = 0;
            else if (st && !sp)  m_run = 1;
        end else if (sp) begin
            m_run = 0;
        end else if (st && !m_run) begin
            if (m_cnt != 0) m_run = 1;
        end else if (m_run) begin
            if (m_cnt > 1) begin
                m_cnt = m_cnt - 1;
            end else begin
                m_done = 1;
                if (ar && m_pre != 0) m_cnt = m_pre;
                else begin m_cnt = 0; m_run = 0; end
            end
        end
    endtask

    initial begin
        // Directed table: start at zero, load+start, auto-reload, pause/resume, reload mid-run.
        vecs.push_back(mk(0,  0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1,  3, 1, 0, 0,  3, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  2, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  1, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  0, 0, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1,  4, 1, 0, 1,  4, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1,  3, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1,  2, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1,  1, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1,  4, 1, 1));
        vecs.push_back(mk(0,  0, 0, 0, 1,  3, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1,  2, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1,  1, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1,  4, 1, 1));
        vecs.push_back(mk(1,  0, 0, 0, 1,  0, 0, 0));
        vecs.push_back(mk(1,  9, 1, 0, 0,  9, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  8, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  7, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  6, 1, 0));
        vecs.push_back(mk(0,  0, 0, 1, 0,  6, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  6, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  6, 0, 0));
        vecs.push_back(mk(0,  0, 1, 0, 0,  6, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  5, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  4, 1, 0));
        vecs.push_back(mk(0,  0, 1, 1, 0,  4, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  4, 0, 0));
        vecs.push_back(mk(0,  0, 1, 0, 0,  4, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  3, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0,  2, 1, 0));
        vecs.push_back(mk(1, 15, 0, 0, 0, 15, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 14, 1, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0,  0, 1, 0, 0,  0, 0, 0));
        // Preset 1 with auto-reload: pulse every cycle, count pinned at 1.
        vecs.push_back(mk(1,  1, 1, 0, 1,  1, 1, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1,  1, 1, 1));
        vecs.push_back(mk(0,  0, 0, 0, 1,  1, 1, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0,  0, 0, 1));
        vecs.push_back(mk(0,  0, 0, 0, 0,  0, 0, 0));

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 0, 0, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk_out("post_reset", 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_step(vecs[i].load, vecs[i].val, vecs[i].start, vecs[i].stop, vecs[i].auto_rl);
            chk_out($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy, vecs[i].e_done);
        end

        // Asynchronous reset in the middle of a run, away from any clock edge.
        drive_step(1'b1, W'(5), 1'b1, 1'b0, 1'b0);
        chk_out("arst_load", 5, 1, 0);
        drive_step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive_step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk_out("arst_pre", 3, 1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("arst_now", 0, 0, 0);
        @(negedge clk);
        chk_out("arst_held", 0, 0, 0);
        reset_n = 1'b1;
        drive_step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk_out("arst_start_ignored", 0, 0, 0);
        drive_step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk_out("arst_idle", 0, 0, 0);

        // Randomized run against the reference model, from a fresh reset.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 600; k++) begin
            bit ld, st, sp, ar;
            int v;
            ld = ($urandom_range(0, 9) == 0);
            v  = (($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, (1 << W) - 1));
            st = ($urandom_range(0, 4) == 0);
            sp = ($urandom_range(0, 11) == 0);
            ar = ($urandom_range(0, 1) == 1);
            drive_step(ld, W'(v), st, sp, ar);
            model_edge(ld, v, st, sp, ar);
            chk_out($sformatf("rand%0d", k), m_cnt, int'(m_run), m_done);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_down_counter_with_reload
